add_rs_scheduler: RTL



---
 rtl/add_rs_scheduler_if.sv | 53 +++++
 rtl/add_rs_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/add_rs_scheduler_if.sv
// Bundle of the dispatch, CDB, flush and add-unit signals between the
// reservation-station scheduler and its neighbours. The scheduler side
// uses the slave modport; the surrounding pipeline uses the master modport.
interface add_rs_scheduler_if #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 3
);
  // mispredict flush
  logic                           flush;
  // dispatch
  logic                           disp_valid;
  logic                           disp_ready;
  logic [2:0]                     disp_op;
  logic [TAG_W-1:0]               disp_rob;
  logic                           disp_q1_pend;
  logic                           disp_q2_pend;
  logic [TAG_W-1:0]               disp_q1_tag;
  logic [TAG_W-1:0]               disp_q2_tag;
  logic [31:0]                    disp_v1;
  logic [31:0]                    disp_v2;
  // common data bus
  logic                           cdb_valid;
  logic [TAG_W-1:0]               cdb_tag;
  logic [31:0]                    cdb_data;
  // add unit
  logic                           fu_valid_out;
  logic                           fu_valid_in;
  logic                           fu_sub;
  logic                           fu_beq;
  logic                           fu_bne;
  logic                           fu_blt;
  logic [TAG_W-1:0]               fu_rob;
  logic [31:0]                    fu_rs1;
  logic [31:0]                    fu_rs2;
  // status
  logic [$clog2(NUM_ENTRIES):0]   occupancy;

  modport master (
    output flush, disp_valid, disp_op, disp_rob, disp_q1_pend, disp_q2_pend,
           disp_q1_tag, disp_q2_tag, disp_v1, disp_v2,
           cdb_valid, cdb_tag, cdb_data, fu_valid_out,
    input  disp_ready, fu_valid_in, fu_sub, fu_beq, fu_bne, fu_blt,
           fu_rob, fu_rs1, fu_rs2, occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_op, disp_rob, disp_q1_pend, disp_q2_pend,
           disp_q1_tag, disp_q2_tag, disp_v1, disp_v2,
           cdb_valid, cdb_tag, cdb_data, fu_valid_out,
    output disp_ready, fu_valid_in, fu_sub, fu_beq, fu_bne, fu_blt,
           fu_rob, fu_rs1, fu_rs2, occupancy
  );
endinterface

// File: rtl/add_rs_scheduler.sv
// Reservation-station scheduler for the add/sub/branch unit.
// Entries wait for their source operands (woken by CDB tag match, including a
// bypass for the op being dispatched) and the oldest ready entry is issued
// whenever the add unit is not holding an unconsumed result. Age is tracked
// with a compact rank per entry: ranks are always 0..occupancy-1.
module add_rs_scheduler #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 3
) (
  input logic               clk,
  input logic               reset,
  add_rs_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = IDX_W + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_BEQ = 3'd2;
  localparam logic [2:0] OP_BNE = 3'd3;
  localparam logic [2:0] OP_BLT = 3'd4;

  // Illegal encodings are allocated normally but behave as ADD.
  function automatic logic [2:0] legal_op(input logic [2:0] op);
    legal_op = (op > OP_BLT) ? OP_ADD : op;
  endfunction

  // entry storage
  logic             valid_r [NUM_ENTRIES];
  logic [2:0]       op_r    [NUM_ENTRIES];
  logic [TAG_W-1:0] rob_r   [NUM_ENTRIES];
  logic             pend1_r [NUM_ENTRIES];
  logic [TAG_W-1:0] tag1_r  [NUM_ENTRIES];
  logic [31:0]      val1_r  [NUM_ENTRIES];
  logic             pend2_r [NUM_ENTRIES];
  logic [TAG_W-1:0] tag2_r  [NUM_ENTRIES];
  logic [31:0]      val2_r  [NUM_ENTRIES];
  logic [IDX_W-1:0] rank_r  [NUM_ENTRIES];
  logic [OCC_W-1:0] occ_r;

  // combinational control
  logic             any_ready_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic [IDX_W-1:0] sel_rank_s;
  logic             has_free_s;
  logic [IDX_W-1:0] free_idx_s;
  logic             issue_s;
  logic             disp_ready_s;
  logic             disp_acc_s;
  logic [IDX_W-1:0] new_rank_s;
  logic             byp1_s;
  logic             byp2_s;
  logic             fu_sub_s;
  logic             fu_beq_s;
  logic             fu_bne_s;
  logic             fu_blt_s;
  logic [TAG_W-1:0] fu_rob_s;
  logic [31:0]      fu_rs1_s;
  logic [31:0]      fu_rs2_s;

  // Oldest-ready select: smallest rank among valid entries with no pending source.
  always_comb begin
    any_ready_s = 1'b0;
    sel_idx_s   = '0;
    sel_rank_s  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_r[i] && !pend1_r[i] && !pend2_r[i] &&
          (!any_ready_s || (rank_r[i] < sel_rank_s))) begin
        any_ready_s = 1'b1;
        sel_idx_s   = IDX_W'(i);
        sel_rank_s  = rank_r[i];
      end else begin
      end
    end
  end

  // Lowest-index free entry for the next dispatch.
  always_comb begin
    has_free_s = 1'b0;
    free_idx_s = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!valid_r[i] && !has_free_s) begin
        has_free_s = 1'b1;
        free_idx_s = IDX_W'(i);
      end else begin
      end
    end
  end

  // Issue/dispatch qualification and the dispatching op's CDB bypass.
  always_comb begin
    issue_s      = !bus.fu_valid_out && any_ready_s && !bus.flush && !reset;
    disp_ready_s = (occ_r < OCC_W'(NUM_ENTRIES));
    disp_acc_s   = bus.disp_valid && disp_ready_s && !bus.flush;
    // an issue this cycle compacts the ranks, so the newcomer slots in one lower
    new_rank_s   = issue_s ? IDX_W'(occ_r - OCC_W'(1)) : IDX_W'(occ_r);
    byp1_s       = bus.cdb_valid && bus.disp_q1_pend && (bus.disp_q1_tag == bus.cdb_tag);
    byp2_s       = bus.cdb_valid && bus.disp_q2_pend && (bus.disp_q2_tag == bus.cdb_tag);
  end

  // Entry state: reset/flush clear, issue frees, dispatch allocates, CDB wakes up.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_r <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        op_r[i]    <= OP_ADD;
        rob_r[i]   <= '0;
        pend1_r[i] <= 1'b0;
        tag1_r[i]  <= '0;
        val1_r[i]  <= 32'd0;
        pend2_r[i] <= 1'b0;
        tag2_r[i]  <= '0;
        val2_r[i]  <= 32'd0;
        rank_r[i]  <= '0;
      end
    end else if (bus.flush) begin
      occ_r <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else begin
      occ_r <= occ_r + OCC_W'(disp_acc_s) - OCC_W'(issue_s);
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (issue_s && (sel_idx_s == IDX_W'(i))) begin
          valid_r[i] <= 1'b0;
        end else if (disp_acc_s && (free_idx_s == IDX_W'(i))) begin
          valid_r[i] <= 1'b1;
          op_r[i]    <= legal_op(bus.disp_op);
          rob_r[i]   <= bus.disp_rob;
          pend1_r[i] <= bus.disp_q1_pend && !byp1_s;
          tag1_r[i]  <= bus.disp_q1_tag;
          val1_r[i]  <= byp1_s ? bus.cdb_data : bus.disp_v1;
          pend2_r[i] <= bus.disp_q2_pend && !byp2_s;
          tag2_r[i]  <= bus.disp_q2_tag;
          val2_r[i]  <= byp2_s ? bus.cdb_data : bus.disp_v2;
          rank_r[i]  <= new_rank_s;
        end else if (valid_r[i]) begin
          if (bus.cdb_valid && pend1_r[i] && (tag1_r[i] == bus.cdb_tag)) begin
            pend1_r[i] <= 1'b0;
            val1_r[i]  <= bus.cdb_data;
          end
          if (bus.cdb_valid && pend2_r[i] && (tag2_r[i] == bus.cdb_tag)) begin
            pend2_r[i] <= 1'b0;
            val2_r[i]  <= bus.cdb_data;
          end
          if (issue_s && (rank_r[i] > sel_rank_s)) begin
            rank_r[i] <= rank_r[i] - IDX_W'(1);
          end
        end
      end
    end
  end

  // Add-unit controls and operands of the selected entry; all zero when idle.
  always_comb begin
    fu_sub_s = 1'b0;
    fu_beq_s = 1'b0;
    fu_bne_s = 1'b0;
    fu_blt_s = 1'b0;
    fu_rob_s = '0;
    fu_rs1_s = 32'd0;
    fu_rs2_s = 32'd0;
    if (issue_s) begin
      fu_rob_s = rob_r[sel_idx_s];
      fu_rs1_s = val1_r[sel_idx_s];
      fu_rs2_s = val2_r[sel_idx_s];
      case (op_r[sel_idx_s])
        OP_SUB:  fu_sub_s = 1'b1;
        OP_BEQ:  begin fu_sub_s = 1'b1; fu_beq_s = 1'b1; end
        OP_BNE:  begin fu_sub_s = 1'b1; fu_bne_s = 1'b1; end
        OP_BLT:  begin fu_sub_s = 1'b1; fu_blt_s = 1'b1; end
        default: fu_sub_s = 1'b0;
      endcase
    end else begin
      fu_rob_s = '0;
    end
  end

  assign bus.disp_ready  = disp_ready_s;
  assign bus.occupancy   = occ_r;
  assign bus.fu_valid_in = issue_s;
  assign bus.fu_sub      = fu_sub_s;
  assign bus.fu_beq      = fu_beq_s;
  assign bus.fu_bne      = fu_bne_s;
  assign bus.fu_blt      = fu_blt_s;
  assign bus.fu_rob      = fu_rob_s;
  assign bus.fu_rs1      = fu_rs1_s;
  assign bus.fu_rs2      = fu_rs2_s;

endmodule
